// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data memory controller.
//   size_e  : RISC-V access size encoding (byte, half, word, double)
//   state_e : controller FSM states (INIT sweeps the array, RUN serves requests)
//   byte_en : byte-enable mask for an access of a given size at a byte offset
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // ((1 << (1 << size)) - 1) << offset, computed 16 bits wide so a
    // misaligned request cannot wrap; callers keep only the low lanes.
    function automatic logic [7:0] byte_en(input logic [1:0] size,
                                           input logic [2:0] offset);
        logic [15:0] mask;
        mask = (16'd1 << (5'd1 << size)) - 16'd1;
        mask = mask << offset;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane steering between the LSU and one memory word.
//   size        in  2       access size (size_e encoding)
//   offset      in  OFF_W   byte offset of the access inside the word
//   is_unsigned in  1       zero-extend loads when 1, sign-extend when 0
//   wdata       in  DATA_W  right-aligned store data
//   rword       in  DATA_W  current contents of the addressed word
//   be          out NB      store byte enables
//   wdata_sh    out DATA_W  store data moved to its byte lanes
//   rdata_ext   out DATA_W  load data extracted and extended to DATA_W
//   misaligned  out 1       offset not a multiple of the size, or double on 32b
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [1:0]        size,
    input  logic [OFF_W-1:0]  offset,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata_ext,
    output logic              misaligned
);

    logic [2:0]        off3;
    logic [2:0]        align_mask;
    logic [7:0]        be_full;
    logic [DATA_W-1:0] rword_sh;
    logic [63:0]       rword_sh64;
    logic [63:0]       ext64;

    assign off3       = 3'(offset);
    assign align_mask = 3'((4'd1 << size) - 4'd1);
    assign misaligned = (|(off3 & align_mask)) || ((size == SZ_D) && (DATA_W == 32));

    assign be_full  = byte_en(size, off3);
    assign be       = be_full[NB-1:0];
    assign wdata_sh = wdata << {offset, 3'b000};

    // Extension is done on a 64-bit view so one case statement serves both
    // word widths; a 32-bit word load simply truncates back to DATA_W.
    assign rword_sh   = rword >> {offset, 3'b000};
    assign rword_sh64 = 64'(rword_sh);

    always_comb begin
        ext64 = rword_sh64;
        case (size)
            SZ_B:    ext64 = {{56{rword_sh64[7]  & ~is_unsigned}}, rword_sh64[7:0]};
            SZ_H:    ext64 = {{48{rword_sh64[15] & ~is_unsigned}}, rword_sh64[15:0]};
            SZ_W:    ext64 = {{32{rword_sh64[31] & ~is_unsigned}}, rword_sh64[31:0]};
            default: ext64 = rword_sh64;
        endcase
    end

    assign rdata_ext = ext64[DATA_W-1:0];

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressed data memory for the load/store path with valid/ready request
// and response handshakes, RISC-V load/store sizing and misalignment errors.
// Optional build macro DMEM_CLEAR_EN: after reset the array is swept to zero
// (one word per cycle) before any request is accepted.
//   i_clk            in  1       clock
//   i_rst_n          in  1       asynchronous active-low reset
//   in_req_valid     in  1       request present
//   out_req_ready    out 1       request can be accepted this cycle
//   in_req_we        in  1       1 = store, 0 = load
//   in_req_addr      in  BA_W    byte address
//   in_req_size      in  2       0 byte, 1 half, 2 word, 3 double (64b only)
//   in_req_unsigned  in  1       load zero-extends when 1
//   in_req_wdata     in  DATA_W  right-aligned store data
//   out_resp_valid   out 1       response present
//   in_resp_ready    in  1       consumer takes the response
//   out_resp_rdata   out DATA_W  extended load data, 0 for stores and errors
//   out_resp_err     out 1       misaligned or unsupported-size access
// -----------------------------------------------------------------------------
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int BA_W   = $clog2(DEPTH * DATA_W / 8)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              in_req_valid,
    output logic              out_req_ready,
    input  logic              in_req_we,
    input  logic [BA_W-1:0]   in_req_addr,
    input  logic [1:0]        in_req_size,
    input  logic              in_req_unsigned,
    input  logic [DATA_W-1:0] in_req_wdata,
    output logic              out_resp_valid,
    input  logic              in_resp_ready,
    output logic [DATA_W-1:0] out_resp_rdata,
    output logic              out_resp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = BA_W - OFF_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  word_idx;
    logic [OFF_W-1:0]  offset;
    logic [DATA_W-1:0] rword;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rdata_ext;
    logic              misaligned;
    logic              run;
    logic              accept_p0;
    logic              store_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;

    assign word_idx = in_req_addr[BA_W-1:OFF_W];
    assign offset   = in_req_addr[OFF_W-1:0];
    assign rword    = mem[word_idx];

`ifdef DMEM_CLEAR_EN
    state_e           state;
    logic [IDX_W-1:0] clr_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else if (state == ST_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    assign run = (state == ST_RUN);
`else
    assign run = 1'b1;
`endif

    dmem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .size        (in_req_size),
        .offset      (offset),
        .is_unsigned (in_req_unsigned),
        .wdata       (in_req_wdata),
        .rword       (rword),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned)
    );

    // The response slot frees up on the same edge it is consumed, so a full
    // slot only stalls the request side when the consumer is also stalled.
    assign out_req_ready = i_rst_n && run && (!vld_p1 || in_resp_ready);
    assign accept_p0     = in_req_valid && out_req_ready;
    assign store_p0      = accept_p0 && in_req_we && !misaligned;

    // ---- stage p0 -> array: byte-masked store (or clear sweep) ----
    always_ff @(posedge i_clk) begin
`ifdef DMEM_CLEAR_EN
        if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else
`endif
        if (store_p0) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // ---- stage p0 -> p1: response register ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            err_p1   <= misaligned;
            rdata_p1 <= (in_req_we || misaligned) ? '0 : rdata_ext;
        end else if (in_resp_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign out_resp_valid = vld_p1;
    assign out_resp_rdata = rdata_p1;
    assign out_resp_err   = err_p1;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data memory for the RISC-V core's load/store path. It extends the earlier fixed 1024x32 byte-enable memory with:
- configurable width and depth
- a valid/ready request and response handshake
- RISC-V load/store sizing with sign/zero extension
- misalignment error reporting
- an optional hardware clear-after-reset sweep

It sits between the LSU and the data array.

## Interface
- DATA_W, 32, word width in bits; legal values 32 or 64.
- DEPTH, 1024, number of words; must be a power of 2.
- BA_W, localparam = $clog2(DEPTH*DATA_W/8), byte-address width.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- in_req_valid  in  1  request present.
- out_req_ready  out  1  request can be accepted this cycle.
- in_req_we  in  1  1 = store, 0 = load.
- in_req_addr  in  BA_W  byte address.
- in_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (double legal only when DATA_W=64).
- in_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- in_req_wdata  in  DATA_W  store data, right-aligned.
- out_resp_valid  out  1  response present.
- in_resp_ready  in  1  consumer accepts the response.
- out_resp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and errors.
- out_resp_err  out  1  the access was misaligned, or was size 3 with DATA_W=32.

## Operation
- A request is accepted on a rising edge where in_req_valid && out_req_ready.
- Address decode:
  - word index = in_req_addr[BA_W-1:$clog2(DATA_W/8)]
  - byte offset = the low bits of in_req_addr
- Alignment: legal when offset mod (1<<size) == 0. An illegal access writes nothing, returns err=1 and rdata=0.
- Store path:
  - Byte enables = ((1<<(1<<size))-1) << offset.
  - wdata is shifted left by offset*8.
  - Only enabled bytes of the addressed word change. A store still produces a response with err=0 and rdata=0.
- Load path:
  - The word is shifted right by offset*8 and truncated to 8<<size bits.
  - The result is then sign- or zero-extended per in_req_unsigned. A full-width load ignores in_req_unsigned.
- Response register: a single entry holding valid, rdata and err.
  - out_req_ready = i_rst_n && state==RUN && (!out_resp_valid || in_resp_ready).
  - A new response replaces the held one on the same edge the old one is consumed.
- FSM states and transitions:
  - INIT → RUN when the clear counter reaches DEPTH-1.
  - RUN → RUN otherwise; no other states.
  - The reset state is INIT with the macro, RUN without it.
- Reset values:
  - out_resp_valid = 0, out_resp_rdata = 0, out_resp_err = 0.
  - out_req_ready = 0 while i_rst_n is low.
  - Clear counter = 0.
- Reset asserted mid-operation drops any pending response. The array contents are untouched by reset itself.

## Timing
- Load latency is 1 cycle: data is accepted at edge N and out_resp_valid is high after edge N.
- Throughput is 1 request/cycle while in_resp_ready stays high.
- out_resp_valid, out_resp_rdata and out_resp_err hold stable while out_resp_valid && !in_resp_ready.
- A load accepted the cycle after a store to the same word returns the stored data.
- out_req_ready is combinational from state and in_resp_ready. It has no path from in_req_valid.

## Configuration
- DMEM_CLEAR_EN defined:
  - After i_rst_n deasserts, the FSM sits in INIT and writes 0 to word[counter] every cycle for DEPTH cycles.
  - out_req_ready is 0 throughout INIT and goes to 1 on the cycle after the last word is written.
  - Reset asserted during INIT restarts the sweep from word 0.
- DMEM_CLEAR_EN undefined:
  - The INIT logic is removed.
  - out_req_ready = 1 in the first cycle after deassertion, if no response is pending.
  - Array contents are undefined until written.

## Structure
- dmem_pkg holds:
  - a size enum: SZ_B, SZ_H, SZ_W, SZ_D
  - an FSM state enum: ST_INIT, ST_RUN
  - a function returning byte enables from size and offset
- Sub-module dmem_lane_align: purely combinational. It performs store shift / byte-enable generation, load extract / extension, and the misalignment check.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 → rdata = 0xDEADBEEF, err = 0, 1-cycle latency.
- Store byte 0x80 to 0x13, then:
  - load byte signed from 0x13 → 0xFFFFFF80
  - load byte unsigned from 0x13 → 0x00000080
  - load word from 0x10 → 0x80ADBEEF
- Load half from 0x11 → err = 1, rdata = 0. Store word to 0x12 → err = 1, and a later load of word 0x10 is unchanged.
- Hold in_resp_ready = 0 for 3 cycles during back-to-back loads → out_req_ready = 0 and the response stays stable. Releasing it gives 1 response per cycle with no loss or duplication.
- With DMEM_CLEAR_EN and DEPTH=16:
  - out_req_ready stays 0 for 16 cycles after reset release.
  - Every word reads 0.
  - Reset pulsed at sweep cycle 8 → ready stays 0 for a further 16 cycles.
- With DATA_W=64: store double 0x0123456789ABCDEF to 0x8 and load double from 0x8 → same value. A size-3 access with DATA_W=32 → err = 1.
